demux_lane_writer: RTL and testbench
====================================

Name: demux_lane_writer

Overview:
- Write-side counterpart of the lane-select multiplexer: accepts one data stream tagged with a lane index `choice` and steers each word into one of LANE_COUNT output lanes.
- Each lane has a one-deep holding register with its own valid/ready handshake.
- The block sits between a single producer and the per-lane consumers (memory banks / register slices), which the read-side multiplexer later selects among.
- It also keeps a sticky out-of-range error flag and a wrapping count of accepted words.

Parameters:
- choice_size, 2, width of the lane index `choice`
- lane_count, 4, number of output lanes; must be <= 2**choice_size and >= 1
- data_size, 5, width of one data word
- count_size, 8, width of the accepted-word counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  global accept enable; when low no input is accepted, but lanes still drain
- in_valid  input  1  producer has a word on data_in/choice
- in_ready  output  1  block accepts the word this cycle
- choice  input  choice_size  destination lane index
- data_in  input  data_size  word to deliver
- out_valid  output  lane_count  per-lane holding register full
- out_ready  input  lane_count  per-lane consumer takes the word
- data_out  output  lane_count x data_size  packed array of per-lane holding registers; lane i is data_out[i]
- err  output  1  sticky: a word with out-of-range choice was dropped
- err_clear  input  1  synchronous clear of err
- xfer_count  output  count_size  number of words delivered to lanes, modulo 2**count_size

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, every data_out lane = 0, err = 0, xfer_count = 0.
  - Reset takes effect immediately mid-transfer; any held words are discarded.
- Clock and reset: one clock domain; all state updates on posedge clk.
- in_ready (combinational):
  - enable && (choice >= lane_count || !out_valid[choice] || out_ready[choice]).
  - Low whenever enable is low.
- Accept: in_valid && in_ready.
  - In range: data_out[choice] <= data_in; out_valid[choice] <= 1; xfer_count increments, wrapping from all-ones to 0.
  - Latency: a word accepted at edge N is visible on data_out/out_valid after edge N.
- Drain: for each lane i, out_valid[i] && out_ready[i] clears out_valid[i] at the edge, unless the same edge refills lane i.
  - Refill on drain (simultaneous) keeps out_valid[i] = 1 and loads the new word; this gives 1 word/cycle per lane.
  - data_out[i] keeps its last value after a drain; it is not zeroed.
  - out_ready[i] while out_valid[i] = 0 has no effect.
- Backpressure: full lane with out_ready low forces in_ready low for that choice only. Other lanes are unaffected on later cycles.
- Out-of-range choice (choice >= lane_count, possible only when lane_count < 2**choice_size):
  - The word is accepted (in_ready high when enable) and dropped.
  - err <= 1; xfer_count is unchanged; no lane is modified.
- err_clear:
  - Clears err at the edge.
  - If an out-of-range accept happens on the same edge, the set wins and err stays 1.
- enable low mid-stream: lanes already holding words remain valid and drain normally; nothing new is loaded.
- Inputs are sampled only on an accept; data_in and choice may change freely otherwise.

Test Plan:
- Reset then idle → out_valid=4'b0000, data_out all 0, err=0, xfer_count=0, in_ready=1 when enable=1.
- in_valid=1, choice=2, data_in=5'h15, out_ready=0, one edge → out_valid=4'b0100, data_out[2]=5'h15, xfer_count=1; next cycle same choice → in_ready=0; choice=1 → in_ready=1.
- Lane 2 full and out_ready[2]=1, with in_valid=1, choice=2, data_in=5'h0A at the same edge → out_valid[2] stays 1, data_out[2]=5'h0A, xfer_count=2 (continuous 1 word/cycle streaming to one lane).
- lane_count=3, choice=3, data_in=5'h1F, in_valid=1 → in_ready=1, err=1, out_valid unchanged, xfer_count unchanged; then err_clear=1 together with another choice=3 accept → err stays 1; err_clear alone → err=0.
- enable=0 with in_valid=1 → in_ready=0 and no state change, while a full lane with out_ready=1 still clears.
- count_size=8: 256 accepted words → xfer_count wraps to 0.
- Assert rst_n low mid-burst with lanes full → out_valid=0 and err=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/demux_lane_writer.sv
// Steers a single tagged data stream into lane_count one-deep holding registers,
// each with its own valid/ready handshake, plus a sticky range error and a word counter.
module demux_lane_writer #(
    parameter int choice_size = 2,
    parameter int lane_count  = 4,
    parameter int data_size   = 5,
    parameter int count_size  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [choice_size-1:0]                choice,
    input  logic [data_size-1:0]                  data_in,
    output logic [lane_count-1:0]                 out_valid,
    input  logic [lane_count-1:0]                 out_ready,
    output logic [lane_count-1:0][data_size-1:0]  data_out,
    output logic                                  err,
    input  logic                                  err_clear,
    output logic [count_size-1:0]                 xfer_count
);

    // One extra bit so lane_count == 2**choice_size compares correctly.
    localparam logic [choice_size:0] lane_limit = (choice_size + 1)'(lane_count);

    logic                  out_of_range;
    logic                  accept;
    logic                  accept_in_range;
    logic                  accept_dropped;
    logic [lane_count-1:0] lane_sel;
    logic [lane_count-1:0] lane_can_take;
    logic                  target_can_take;

    logic                  err_d, err_q;
    logic [count_size-1:0] count_d, count_q;

    assign out_of_range    = ({1'b0, choice} >= lane_limit);
    assign target_can_take = |(lane_sel & lane_can_take);
    assign in_ready        = enable && (out_of_range || target_can_take);
    assign accept          = in_valid && in_ready;
    assign accept_in_range = accept && !out_of_range;
    assign accept_dropped  = accept && out_of_range;

    generate
        for (genvar gi = 0; gi < lane_count; gi++) begin : g_lane
            logic                 valid_d, valid_q;
            logic [data_size-1:0] data_d, data_q;
            logic                 load;
            logic                 drain;

            assign lane_sel[gi]      = (choice == choice_size'(gi));
            assign lane_can_take[gi] = !valid_q || out_ready[gi];
            assign load              = accept_in_range && lane_sel[gi];
            assign drain             = valid_q && out_ready[gi];

            // A refill on the same edge as a drain keeps the lane full.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = data_in;
                end else if (drain) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid[gi] = valid_q;
            assign data_out[gi]  = data_q;
        end
    endgenerate

    // A dropped word on the same edge as a clear leaves the flag set.
    always_comb begin
        err_d = err_q;
        if (err_clear) begin
            err_d = 1'b0;
        end
        if (accept_dropped) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept_in_range) begin
            count_d = count_q + count_size'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign err        = err_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux_lane_writer.sv
// Directed bench for demux_lane_writer: a 4-lane instance for the main paths and
// a 3-lane instance for out-of-range handling; both share clock and reset.
module tb_demux_lane_writer;

    logic clk;
    logic rst_n;

    logic            a_enable, a_in_valid, a_in_ready, a_err, a_err_clear;
    logic [1:0]      a_choice;
    logic [4:0]      a_data_in;
    logic [3:0]      a_out_valid, a_out_ready;
    logic [3:0][4:0] a_data_out;
    logic [7:0]      a_xfer_count;

    logic            b_enable, b_in_valid, b_in_ready, b_err, b_err_clear;
    logic [1:0]      b_choice;
    logic [4:0]      b_data_in;
    logic [2:0]      b_out_valid, b_out_ready;
    logic [2:0][4:0] b_data_out;
    logic [7:0]      b_xfer_count;

    int total;
    int bad;

    demux_lane_writer dut_a (
        .clk(clk), .rst_n(rst_n), .enable(a_enable), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .choice(a_choice), .data_in(a_data_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
        .err(a_err), .err_clear(a_err_clear), .xfer_count(a_xfer_count)
    );

    demux_lane_writer #(.lane_count(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .choice(b_choice), .data_in(b_data_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
        .err(b_err), .err_clear(b_err_clear), .xfer_count(b_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        a_enable = 1'b1; a_in_valid = 1'b0; a_err_clear = 1'b0;
        a_choice = 2'd0; a_data_in = 5'h00; a_out_ready = 4'b0000;
        b_enable = 1'b1; b_in_valid = 1'b0; b_err_clear = 1'b0;
        b_choice = 2'd0; b_data_in = 5'h00; b_out_ready = 3'b000;

        // Reset and idle
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_data_out", 32'(a_data_out), 32'h0);
        check("rst_err", 32'(a_err), 32'h0);
        check("rst_count", 32'(a_xfer_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(a_in_ready), 32'h1);

        // Single word into lane 2
        a_in_valid = 1'b1; a_choice = 2'd2; a_data_in = 5'h15; a_out_ready = 4'b0000;
        tick();
        a_in_valid = 1'b0;
        check("l2_out_valid", 32'(a_out_valid), 32'h4);
        check("l2_data", 32'(a_data_out[2]), 32'h15);
        check("l2_count", 32'(a_xfer_count), 32'h1);
        check("l2_full_ready", 32'(a_in_ready), 32'h0);
        a_choice = 2'd1;
        #1;
        check("l1_ready_while_l2_full", 32'(a_in_ready), 32'h1);

        // Refill on drain, two consecutive words
        a_choice = 2'd2; a_data_in = 5'h0A; a_in_valid = 1'b1; a_out_ready = 4'b0100;
        #1;
        check("refill_ready", 32'(a_in_ready), 32'h1);
        tick();
        check("refill_valid", 32'(a_out_valid), 32'h4);
        check("refill_data", 32'(a_data_out[2]), 32'h0A);
        check("refill_count", 32'(a_xfer_count), 32'h2);
        a_data_in = 5'h03;
        tick();
        check("stream_data", 32'(a_data_out[2]), 32'h03);
        check("stream_count", 32'(a_xfer_count), 32'h3);
        a_in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(a_out_valid), 32'h0);
        check("drain_keeps_data", 32'(a_data_out[2]), 32'h03);

        // enable low: nothing loaded, full lane still drains
        a_in_valid = 1'b1; a_choice = 2'd0; a_data_in = 5'h11; a_out_ready = 4'b0000;
        tick();
        check("l0_fill_valid", 32'(a_out_valid), 32'h1);
        check("l0_fill_count", 32'(a_xfer_count), 32'h4);
        a_enable = 1'b0; a_choice = 2'd1; a_data_in = 5'h1E; a_out_ready = 4'b0001;
        #1;
        check("disabled_ready", 32'(a_in_ready), 32'h0);
        tick();
        check("disabled_drain_valid", 32'(a_out_valid), 32'h0);
        check("disabled_no_load", 32'(a_data_out[1]), 32'h00);
        check("disabled_count", 32'(a_xfer_count), 32'h4);
        a_enable = 1'b1;

        // Backpressure on lane 3 only
        a_choice = 2'd3; a_data_in = 5'h07; a_out_ready = 4'b0000;
        tick();
        check("l3_fill_valid", 32'(a_out_valid), 32'h8);
        check("l3_blocked_ready", 32'(a_in_ready), 32'h0);
        a_data_in = 5'h1C;
        tick();
        check("l3_blocked_count", 32'(a_xfer_count), 32'h5);
        check("l3_blocked_data", 32'(a_data_out[3]), 32'h07);
        a_choice = 2'd0; a_data_in = 5'h0C;
        #1;
        check("l0_ready_l3_full", 32'(a_in_ready), 32'h1);
        tick();
        check("l0_l3_valid", 32'(a_out_valid), 32'h9);
        check("l0_l3_count", 32'(a_xfer_count), 32'h6);

        // Counter wrap: stream 250 words into lane 1
        a_choice = 2'd1; a_out_ready = 4'b0010;
        for (int i = 0; i < 249; i++) begin
            a_data_in = 5'(i);
            tick();
        end
        check("count_255", 32'(a_xfer_count), 32'hFF);
        a_data_in = 5'h19;
        tick();
        check("count_wrap", 32'(a_xfer_count), 32'h00);
        a_in_valid = 1'b0; a_out_ready = 4'b0000;
        tick();
        check("post_wrap_valid", 32'(a_out_valid), 32'hB);
        check("post_wrap_data", 32'(a_data_out[1]), 32'h19);

        // Out-of-range on the 3-lane instance
        b_in_valid = 1'b1; b_choice = 2'd3; b_data_in = 5'h1F;
        #1;
        check("oor_ready", 32'(b_in_ready), 32'h1);
        tick();
        check("oor_err", 32'(b_err), 32'h1);
        check("oor_valid", 32'(b_out_valid), 32'h0);
        check("oor_count", 32'(b_xfer_count), 32'h0);
        b_choice = 2'd0; b_data_in = 5'h05;
        tick();
        check("b_l0_valid", 32'(b_out_valid), 32'h1);
        check("b_l0_count", 32'(b_xfer_count), 32'h1);
        check("b_err_sticky", 32'(b_err), 32'h1);
        b_choice = 2'd3; b_err_clear = 1'b1;
        tick();
        check("clear_vs_set", 32'(b_err), 32'h1);
        check("clear_vs_set_count", 32'(b_xfer_count), 32'h1);
        b_in_valid = 1'b0;
        tick();
        check("clear_alone", 32'(b_err), 32'h0);
        b_err_clear = 1'b0; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("oor_err_again", 32'(b_err), 32'h1);

        // Asynchronous reset mid-burst
        a_in_valid = 1'b1; a_choice = 2'd2; a_data_in = 5'h0F;
        tick();
        check("pre_rst_valid", 32'(a_out_valid), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a_out_valid), 32'h0);
        check("async_rst_data", 32'(a_data_out), 32'h0);
        check("async_rst_count", 32'(a_xfer_count), 32'h0);
        check("async_rst_b_err", 32'(b_err), 32'h0);
        check("async_rst_b_valid", 32'(b_out_valid), 32'h0);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
